// File: rtl/pb_audio_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pb_audio_player
//  Purpose  : PicoBlaze-fed sample FIFO with primed playback state machine,
//             sample-rate tick and glitch-free 8-bit PWM audio output.
//  Options  : define AUDIO_SAMPLE_SIGNED_EN to treat samples as two's
//             complement (bit 7 inverted when loaded into the duty register).
//  Revision : 1.0  initial release
// ============================================================================
module pb_audio_player #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SAMPLE_DIV  = 12500,
  parameter int PRIME_LEVEL = FIFO_DEPTH / 2
) (
  input  logic       clk,
  input  logic       pb_reset,
  input  logic [7:0] sample_in,
  input  logic       write_sample,
  input  logic       play_en,
  input  logic       clear_flags,
  output logic       fifo_full,
  output logic [7:0] fifo_level,
  output logic       underrun,
  output logic       overflow,
  output logic       playing,
  output logic       audio_pwm
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_COUNT = CW'(PRIME_LEVEL);
  localparam logic [7:0]    MIDSCALE    = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    duty;
  logic [7:0]    duty_active;
  logic [7:0]    pwm_cnt;
  logic [7:0]    head;
  logic [7:0]    duty_load;
  logic          fifo_empty;
  logic          tick;
  logic          push;
  logic          pop;
  logic          drop;
  logic          underrun_set;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_COUNT);
  assign fifo_level   = 8'(count);
  assign tick         = (state == PLAY) && (tick_cnt == TICK_LAST);
  // A tick with play_en low is ignored: the FSM heads to IDLE and keeps the data.
  assign pop          = tick && play_en && !fifo_empty;
  assign underrun_set = tick && play_en && fifo_empty;
  // A pop in the same cycle does not make room for a write that found the FIFO full.
  assign push         = write_sample && !fifo_full;
  assign drop         = write_sample && fifo_full;
  assign head         = mem[rd_ptr];

`ifdef AUDIO_SAMPLE_SIGNED_EN
  assign duty_load = {~head[7], head[6:0]};
`else
  assign duty_load = head;
`endif

  // Sample storage; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !pb_reset) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag (set beats clear).
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

  // Playback FSM with sample-tick counter, duty register and underrun flag.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      state    <= IDLE;
      playing  <= 1'b0;
      underrun <= 1'b0;
      tick_cnt <= '0;
      duty     <= MIDSCALE;
    end else begin
      // Counter only runs in PLAY, so it is already zero on every entry.
      tick_cnt <= (state == PLAY && !tick) ? tick_cnt + TW'(1) : '0;
      if (underrun_set)     underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
      if (!play_en) begin
        state   <= IDLE;
        playing <= 1'b0;
        duty    <= MIDSCALE;
      end else begin
        case (state)
          IDLE: begin
            state <= PRIME;
          end
          PRIME: begin
            if (count >= PRIME_COUNT) begin
              state   <= PLAY;
              playing <= 1'b1;
            end
          end
          PLAY: begin
            if (underrun_set) begin
              state   <= PRIME;
              playing <= 1'b0;
            end else if (pop) begin
              duty <= duty_load;
            end
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

  // Free-running PWM; duty is only adopted at the period boundary.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      pwm_cnt     <= 8'd0;
      duty_active <= MIDSCALE;
      audio_pwm   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) duty_active <= duty;
      audio_pwm <= (pwm_cnt < duty_active);
    end
  end

endmodule
`default_nettype wire
